// File: rtl/acc_pkg.sv
// Shared types for the ABFT column accumulator and its sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package acc_pkg;

  // Sequencer phases for one checksum pass.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC0  = 2'd1,
    SWEEP = 2'd2,
    CHECK = 2'd3
  } acc_seq_state_t;

endpackage

// File: rtl/acc_nxn_seq.sv
// Purpose: sequences one ABFT checksum pass through acc_nxn and checks its total z.
//   The array output stream is gated into the stage-0 inputs. The stage-1 selector
//   is swept across the column totals. z is compared against ref_sum.
// Latency: done pulses arraySize+2 cycles after the last accepted beat.
// Backpressure: in_ready is high only in ACC0; beats offered in any other state are dropped.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start/num_rows/ref_sum  pass request, sampled in IDLE only
//   in_valid/in_data/in_ready  array output beats, column j at [j*aBits +: aBits]
//   a_out/clear_0/selector/clear_1  combinational drive into acc_nxn
//   z_in                stage-1 total from acc_nxn
//   done/error/result/err_cnt  pass outcome, held until the next done
module acc_nxn_seq
  import acc_pkg::*;
#(
  parameter int arraySize    = 4,
  parameter int addressWidth = 2,
  parameter int aBits        = 20,
  parameter int yBits        = 24,
  parameter int zBits        = 28,
  parameter int countBits    = 16,
  parameter int errBits      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [countBits-1:0]       num_rows,
  input  logic [zBits-1:0]           ref_sum,
  input  logic                       in_valid,
  input  logic [arraySize*aBits-1:0] in_data,
  output logic                       in_ready,
  output logic [arraySize*aBits-1:0] a_out,
  output logic [arraySize-1:0]       clear_0,
  output logic [addressWidth-1:0]    selector,
  output logic                       clear_1,
  input  logic [zBits-1:0]           z_in,
  output logic                       done,
  output logic                       error,
  output logic [zBits-1:0]           result,
  output logic [errBits-1:0]         err_cnt
);

  localparam logic [addressWidth-1:0] LastSel = addressWidth'(arraySize - 1);
  localparam logic [countBits-1:0]    OneBeat = countBits'(1);
  localparam logic [errBits-1:0]      ErrMax  = {errBits{1'b1}};

  // The stage-0 accumulators must be able to hold at least one raw sample.
  if (yBits < aBits) begin : g_ybits_check
    $error("acc_nxn_seq: yBits must not be narrower than aBits");
  end

  acc_seq_state_t              state_q, state_d;
  logic [countBits-1:0]        beat_cnt_q, beat_cnt_d;
  logic [countBits-1:0]        num_rows_q, num_rows_d;
  logic [zBits-1:0]            ref_sum_q, ref_sum_d;
  logic [addressWidth-1:0]     sweep_cnt_q, sweep_cnt_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;
  logic [zBits-1:0]            result_q, result_d;
  logic [errBits-1:0]          err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      num_rows_q  <= '0;
      ref_sum_q   <= '0;
      sweep_cnt_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      result_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      num_rows_q  <= num_rows_d;
      ref_sum_q   <= ref_sum_d;
      sweep_cnt_q <= sweep_cnt_d;
      done_q      <= done_d;
      error_q     <= error_d;
      result_q    <= result_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    num_rows_d  = num_rows_q;
    ref_sum_d   = ref_sum_q;
    sweep_cnt_d = sweep_cnt_q;
    done_d      = 1'b0;
    error_d     = error_q;
    result_d    = result_q;
    err_cnt_d   = err_cnt_q;

    in_ready = 1'b0;
    a_out    = '0;
    clear_0  = '0;
    clear_1  = 1'b0;
    // The sweep counter rests at zero outside SWEEP, so it can drive the selector directly.
    selector = sweep_cnt_q;

    case (state_q)
      IDLE: begin
        // A zero-row pass has nothing to check and is dropped.
        if (start && (num_rows != '0)) begin
          num_rows_d = num_rows;
          ref_sum_d  = ref_sum;
          beat_cnt_d = '0;
          state_d    = ACC0;
        end
      end

      ACC0: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_out = in_data;
          // The first beat reloads every column total, discarding the previous pass.
          clear_0    = (beat_cnt_q == '0) ? {arraySize{1'b1}} : '0;
          beat_cnt_d = beat_cnt_q + OneBeat;
          if (beat_cnt_q == (num_rows_q - OneBeat)) begin
            sweep_cnt_d = '0;
            state_d     = SWEEP;
          end
        end
      end

      SWEEP: begin
        // The first selected column reloads the stage-1 total; the rest add to it.
        clear_1 = (sweep_cnt_q == '0);
        if (sweep_cnt_q == LastSel) begin
          sweep_cnt_d = '0;
          state_d     = CHECK;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end

      CHECK: begin
        result_d = z_in;
        error_d  = (z_in != ref_sum_q);
        if ((z_in != ref_sum_q) && (err_cnt_q != ErrMax)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done    = done_q;
  assign error   = error_q;
  assign result  = result_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: doc/acc_nxn_seq.md
# acc_nxn_seq

Sequencer and checker that drives the two-stage column accumulator `acc_nxn` for one ABFT checksum pass.
- Gates a systolic-array output stream into the per-column stage-0 inputs and generates the stage-0 clears.
- Sweeps the stage-1 selector across the column totals.
- Compares the resulting total `z` against a reference checksum and reports pass/fail with a one-cycle `done` pulse.
- Sits directly upstream of `acc_nxn` (it drives its `a_*`, `clear_0_*`, `selector`, `clear_1`) and also consumes its `z`.

## Interface
Parameters:
- arraySize, 4, number of columns / stage-0 accumulators
- addressWidth, 2, selector width, clog2(arraySize)
- aBits, 20, per-column input sample width
- yBits, 24, stage-0 accumulator width (informational, matches `acc_nxn`)
- zBits, 28, stage-1 total width
- countBits, 16, row-count width
- errBits, 16, mismatch counter width

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled in IDLE only
- num_rows  in  countBits  valid beats per pass; sampled with start
- ref_sum  in  zBits  expected checksum; sampled with start
- in_valid  in  1  array output beat valid
- in_data  in  arraySize*aBits  column j at bits [j*aBits +: aBits]
- in_ready  out  1  high while in ACC0
- a_out  out  arraySize*aBits  to `acc_nxn` a_j, same packing
- clear_0  out  arraySize  to `acc_nxn` clear_0_j
- selector  out  addressWidth  to `acc_nxn` selector
- clear_1  out  1  to `acc_nxn` clear_1
- z_in  in  zBits  from `acc_nxn` z
- done  out  1  one-cycle pass-complete pulse
- error  out  1  mismatch flag, valid with done, held until next done
- result  out  zBits  captured z_in, held until next done
- err_cnt  out  errBits  saturating mismatch count

## Operation
- `acc_n` contract (both stages): when clear=1, out <= a; otherwise out <= out + a. Outputs are registered.
- FSM states: IDLE, ACC0, SWEEP, CHECK.
- IDLE
  - start=1 with num_rows≠0: latch num_rows and ref_sum, go to ACC0.
  - start with num_rows=0 is ignored.
- ACC0
  - in_ready=1.
  - On an in_valid beat: a_out=in_data, and all clear_0 bits =1 if it is the first beat of the pass, else 0.
  - On a non-valid cycle: a_out=0 and clear_0=0, so the totals hold.
  - After beat number num_rows, go to SWEEP.
- SWEEP
  - Lasts arraySize cycles; selector = 0..arraySize-1.
  - clear_1=1 only when selector=0.
  - a_out=0 and clear_0=0 throughout.
  - After the last cycle, go to CHECK.
- CHECK
  - One cycle. Register result<=z_in and error<=(z_in≠ref_sum).
  - If mismatch, increment err_cnt, saturating at all-ones.
  - Return to IDLE; done=1 in the next cycle.
- start outside IDLE is ignored. in_valid outside ACC0 is ignored: a_out=0, clear_0=0.
- Comparison is full zBits width, unsigned. Overflow inside `acc_nxn` is not detected here.

## Timing
- Reset values:
  - state IDLE, in_ready=0, a_out=0, clear_0=0, selector=0, clear_1=0.
  - done=0, error=0, result=0, err_cnt=0.
- Outputs to `acc_nxn` are combinational from state, counters and in_data/in_valid.
  - No extra register stage, so stage-0 samples land at the edge ending the beat.
- Last valid beat in cycle t:
  - SWEEP occupies t+1..t+arraySize.
  - CHECK is at t+arraySize+1, where z_in is final.
  - done is high at t+arraySize+2.
- A new start is accepted in the cycle done is high, so back-to-back passes are possible.
- Reset asserted mid-pass: immediate return to IDLE with all outputs at reset values. No done; err_cnt is cleared.

## Structure
- Shared package `acc_pkg`: FSM state enum `acc_seq_state_t` {IDLE, ACC0, SWEEP, CHECK}.
- Counters
  - Beat counter: countBits wide.
  - Sweep counter: addressWidth wide, drives selector directly.
- No sub-module is needed. The block is instantiated beside `acc_nxn` in the ABFT top, not inside it.

## Test plan
- Defaults, num_rows=3, ref_sum=12, all columns =1 on 3 consecutive beats.
  - Expect z_in=12, done at last beat+6, error=0, result=12, err_cnt=0.
- Same stimulus with ref_sum=13.
  - Expect error=1, result=12, err_cnt=1. Repeat until err_cnt saturates at 16'hFFFF and check it holds.
- num_rows=4 with in_valid bubbles (valid pattern 1,0,0,1,1,0,1), columns j = j+1.
  - Expect column totals 4,8,12,16 and z=40. Clears only on the first beat.
- Reset asserted during ACC0 after 2 beats, then a fresh pass with num_rows=2, data 5.
  - Expect no done from the aborted pass, and the new pass gives z=40.
- start during SWEEP, start with num_rows=0, and in_valid in IDLE.
  - All ignored: no state change, a_out=0.
- Back-to-back: start asserted in the done cycle.
  - Second pass accepted, first beat reloads via clear_0, independent result.
